// File: rtl/crank_wheel_gen.sv
// ---------------------------------------------------------------------------
// crank_wheel_gen
//   Missing-tooth crankshaft wheel signal generator (e.g. 60-2). It produces
//   a registered tooth waveform with a programmable tooth pitch. Used for
//   on-board self-test, loopback into the tooth-wheel capture block, and as
//   a simulation stimulus source.
//
// Ports
//   clk        : module clock
//   rst        : synchronous active-high reset
//   en         : 1 = generate; 0 = stop at the next slot boundary
//   period     : tooth pitch in clk cycles, sampled at each slot start
//                (values 0..3 are clamped to 4)
//   cap        : registered wheel signal (tooth level = ~CAP_INV)
//   tooth_idx  : current slot number, 0..TEETH_TOTAL-1
//   rev_strobe : one-cycle pulse in the first cycle of slot 0
//   busy       : 1 while generating or draining the current slot
// ---------------------------------------------------------------------------
module crank_wheel_gen #(
  parameter int TEETH_TOTAL   = 60,
  parameter int TEETH_MISSING = 2,
  parameter int PER_WIDTH     = 24,
  parameter int TCNT_WIDTH    = 6,
  parameter bit CAP_INV       = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [PER_WIDTH-1:0]  period,
  output logic                  cap,
  output logic [TCNT_WIDTH-1:0] tooth_idx,
  output logic                  rev_strobe,
  output logic                  busy
);

  localparam logic [TCNT_WIDTH-1:0] LAST_SLOT  = TCNT_WIDTH'(TEETH_TOTAL - 1);
  localparam logic [TCNT_WIDTH-1:0] PHYS_SLOTS = TCNT_WIDTH'(TEETH_TOTAL - TEETH_MISSING);
  localparam logic [PER_WIDTH-1:0]  MIN_PER    = PER_WIDTH'(4);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [PER_WIDTH-1:0]    ph_q, ph_d;      // phase within the current slot
  logic [PER_WIDTH-1:0]    p_q, p_d;        // active (latched) slot length
  logic [TCNT_WIDTH-1:0]   idx_q, idx_d;
  logic                    cap_q, cap_d;
  logic                    rev_q, rev_d;

  logic [PER_WIDTH-1:0]    per_clamped;
  logic                    slot_end;
  logic                    tooth_on;

  // ---------------------------------------------------------------------
  // Next-state logic. The outputs are registered, so cap/rev_strobe are
  // derived from the *next* phase/slot/period so they line up with the
  // counters they describe.
  // ---------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    ph_d        = ph_q;
    p_d         = p_q;
    idx_d       = idx_q;
    per_clamped = (period < MIN_PER) ? MIN_PER : period;
    // p_q is never below 4, so p_q-1 cannot underflow; ph never exceeds
    // P-1, so the phase counter cannot overflow even for P = 2^W-1.
    slot_end    = (ph_q == (p_q - PER_WIDTH'(1)));

    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d = ST_RUN;
          ph_d    = '0;
          idx_d   = '0;
          p_d     = per_clamped;
        end
      end

      ST_RUN, ST_DRAIN: begin
        if (slot_end) begin
          // Slot boundary: en decides between a normal advance and a stop.
          // A slot is never truncated, whatever en did inside it.
          ph_d = '0;
          if (en) begin
            state_d = ST_RUN;
            idx_d   = (idx_q == LAST_SLOT) ? '0 : idx_q + TCNT_WIDTH'(1);
            p_d     = per_clamped;
          end else begin
            state_d = ST_IDLE;
            idx_d   = '0;
          end
        end else begin
          ph_d = ph_q + PER_WIDTH'(1);
          if ((state_q == ST_RUN) && !en) begin
            state_d = ST_DRAIN;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        ph_d    = '0;
        idx_d   = '0;
      end
    endcase

    // Tooth is active for the first floor(P/2) cycles of a physical slot.
    tooth_on = (state_d != ST_IDLE) && (idx_d < PHYS_SLOTS) && (ph_d < (p_d >> 1));
    cap_d    = tooth_on ^ CAP_INV;
    rev_d    = (state_d != ST_IDLE) && (idx_d == '0) && (ph_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ph_q    <= '0;
      p_q     <= MIN_PER;
      idx_q   <= '0;
      cap_q   <= CAP_INV;
      rev_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      p_q     <= p_d;
      idx_q   <= idx_d;
      cap_q   <= cap_d;
      rev_q   <= rev_d;
    end
  end

  assign cap        = cap_q;
  assign tooth_idx  = idx_q;
  assign rev_strobe = rev_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_crank_wheel_gen.sv
// ---------------------------------------------------------------------------
// tb_crank_wheel_gen
//   Self-checking bench for crank_wheel_gen. A slot-level reference model
//   (active flag, slot number, position in slot, slot length) predicts all
//   outputs every cycle. Directed scenarios cover the nominal 60-2 wheel,
//   odd period, mid-slot period change, clamping, stop/restart and reset;
//   a randomized phase then mixes en/period/rst changes. A second instance
//   with CAP_INV = 1 runs in parallel and must show the inverted waveform.
// ---------------------------------------------------------------------------
module tb_crank_wheel_gen;

  localparam int TOTAL   = 60;
  localparam int MISSING = 2;
  localparam int PHYS    = TOTAL - MISSING;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [23:0] period = 24'd8;

  logic        cap, rev_strobe, busy;
  logic [5:0]  tooth_idx;
  logic        cap_i, rev_i, busy_i;
  logic [5:0]  idx_i;

  always #5 clk = ~clk;

  crank_wheel_gen #(.CAP_INV(1'b0)) dut (
    .clk(clk), .rst(rst), .en(en), .period(period),
    .cap(cap), .tooth_idx(tooth_idx), .rev_strobe(rev_strobe), .busy(busy)
  );

  crank_wheel_gen #(.CAP_INV(1'b1)) dut_inv (
    .clk(clk), .rst(rst), .en(en), .period(period),
    .cap(cap_i), .tooth_idx(idx_i), .rev_strobe(rev_i), .busy(busy_i)
  );

  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model (slot level) ----------------
  bit m_active;
  int m_slot;
  int m_pos;
  int m_len;

  function automatic int clamp_per(input int p);
    return (p < 4) ? 4 : p;
  endfunction

  task automatic model_reset();
    m_active = 0; m_slot = 0; m_pos = 0; m_len = 4;
  endtask

  // Advance the model by one clock with the inputs seen at that edge.
  task automatic model_step(input bit e, input int p);
    if (!m_active) begin
      if (e) begin
        m_active = 1; m_slot = 0; m_pos = 0; m_len = clamp_per(p);
      end
    end else if (m_pos == m_len - 1) begin
      if (e) begin
        m_slot = (m_slot + 1) % TOTAL; m_pos = 0; m_len = clamp_per(p);
      end else begin
        m_active = 0; m_slot = 0; m_pos = 0;
      end
    end else begin
      m_pos++;
    end
  endtask

  // ---------------- revolution measurement (from DUT pins) ----------------
  int cyc;
  int prev_rev;
  int last_int;
  int last_high;
  int high_acc;

  task automatic meas_reset();
    prev_rev = -1; last_int = 0; last_high = 0; high_acc = 0;
  endtask

  task automatic compare_all();
    bit tooth;
    tooth = m_active && (m_slot < PHYS) && (m_pos < m_len / 2);
    check_val("cap",        32'(cap),        32'(tooth));
    check_val("cap_inv",    32'(cap_i),      32'(!tooth));
    check_val("tooth_idx",  32'(tooth_idx),  32'(m_slot));
    check_val("rev_strobe", 32'(rev_strobe), 32'(m_active && m_slot == 0 && m_pos == 0));
    check_val("busy",       32'(busy),       32'(m_active));
    check_val("busy_inv",   32'(busy_i),     32'(m_active));
  endtask

  task automatic step(input bit e, input int p);
    en = e;
    period = 24'(p);
    model_step(e, p);
    @(posedge clk);
    #1;
    cyc++;
    if (rev_strobe) begin
      if (prev_rev >= 0) begin
        last_int  = cyc - prev_rev;
        last_high = high_acc;
      end
      prev_rev = cyc;
      high_acc = 0;
    end
    if (cap) high_acc++;
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    model_reset();
    meas_reset();
    check_val("rst_cap",     32'(cap),        32'd0);
    check_val("rst_cap_inv", 32'(cap_i),      32'd1);
    check_val("rst_idx",     32'(tooth_idx),  32'd0);
    check_val("rst_rev",     32'(rev_strobe), 32'd0);
    check_val("rst_busy",    32'(busy),       32'd0);
    rst = 1'b0;
  endtask

  // Run with constant inputs until the model reaches (slot, pos), bounded.
  task automatic run_to(input int slot, input int pos, input int p, input string tag);
    int n;
    n = 0;
    while (!(m_active && m_slot == slot && m_pos == pos) && n < 5000) begin
      step(1, p);
      n++;
    end
    check_val(tag, 32'(m_active && m_slot == slot && m_pos == pos), 32'd1);
  endtask

  initial begin
    cyc = 0;
    model_reset();
    meas_reset();

    // Nominal 60-2 wheel at period 8
    do_reset();
    for (int i = 0; i < 1000; i++) step(1, 8);
    check_val("rev_len_p8",  32'(last_int),  32'd480);
    check_val("rev_high_p8", 32'(last_high), 32'(PHYS * 4));
    $display("scenario p8: rev_len=%0d high=%0d", last_int, last_high);

    // Odd period: 4 high / 5 low
    do_reset();
    for (int i = 0; i < 1100; i++) step(1, 9);
    check_val("rev_len_p9",  32'(last_int),  32'd540);
    check_val("rev_high_p9", 32'(last_high), 32'(PHYS * 4));
    $display("scenario p9: rev_len=%0d high=%0d", last_int, last_high);

    // Period change 8 -> 16 at ph = 2 of slot 10
    do_reset();
    run_to(10, 2, 8, "reach_s10_ph2");
    for (int i = 0; i < 6; i++) step(1, 16);
    check_val("s10_kept_8", 32'(tooth_idx), 32'd11);
    for (int i = 0; i < 1000; i++) step(1, 16);
    $display("scenario period change: slot=%0d", tooth_idx);

    // period = 0 clamps to 4
    do_reset();
    for (int i = 0; i < 500; i++) step(1, 0);
    check_val("rev_len_p0", 32'(last_int), 32'd240);
    $display("scenario clamp: rev_len=%0d", last_int);

    // Stop in slot 5 and restart from DRAIN
    do_reset();
    run_to(5, 1, 8, "reach_s5_ph1");
    for (int i = 0; i < 6; i++) step(0, 8);
    check_val("drain_busy", 32'(busy), 32'd1);
    step(0, 8);
    check_val("stop_busy", 32'(busy), 32'd0);
    check_val("stop_idx",  32'(tooth_idx), 32'd0);
    check_val("stop_cap",  32'(cap), 32'd0);
    run_to(5, 1, 8, "reach_s5_ph1_b");
    for (int i = 0; i < 3; i++) step(0, 8);
    for (int i = 0; i < 4; i++) step(1, 8);
    check_val("resume_idx", 32'(tooth_idx), 32'd6);
    $display("scenario stop/restart: idx=%0d busy=%0d", tooth_idx, busy);

    // Reset mid-slot
    run_to(20, 3, 8, "reach_s20_ph3");
    en = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    model_reset();
    meas_reset();
    check_val("mid_rst_cap",  32'(cap),        32'd0);
    check_val("mid_rst_idx",  32'(tooth_idx),  32'd0);
    check_val("mid_rst_rev",  32'(rev_strobe), 32'd0);
    check_val("mid_rst_busy", 32'(busy),       32'd0);
    rst = 1'b0;
    $display("scenario mid-slot reset done");

    // Randomized phase
    begin
      bit e;
      int p;
      e = 1;
      p = 8;
      for (int i = 0; i < 20000 && err_cnt < 20; i++) begin
        if ($urandom_range(0, 63) == 0)  p = $urandom_range(0, 12);
        if ($urandom_range(0, 149) == 0) e = ~e;
        if ($urandom_range(0, 2999) == 0) begin
          do_reset();
        end else begin
          step(e, p);
        end
      end
    end
    $display("scenario random done: cycles=%0d", cyc);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/crank_wheel_gen.md
Name: crank_wheel_gen

Overview:
- Synthesizable crankshaft-sensor signal generator. It is the transmitter counterpart of the 60-2 tooth-wheel capture/angle generator.
- Produces a missing-tooth wheel waveform with programmable tooth pitch. Used for on-board self-test and bench loopback into the capture input, and as a simulation stimulus source.
- Sits in the same clock domain as the angle generator; its cap output connects directly to that block's cap input.

Parameters:
- TEETH_TOTAL, 60, tooth slots per revolution, physical plus missing.
- TEETH_MISSING, 2, number of slots at the end of the revolution with no tooth.
- PER_WIDTH, 24, width of the tooth-pitch period in clocks.
- TCNT_WIDTH, 6, width of tooth_idx; must satisfy 2^TCNT_WIDTH >= TEETH_TOTAL.
- CAP_INV, 0, 1 inverts cap so the tooth is low and the gap/idle level is high.

Ports:
- clk  in  1  module clock.
- rst  in  1  reset. Synchronous, active-high, single clock domain.
- en  in  1  level; 1 = generate, 0 = stop at the next slot boundary.
- period  in  PER_WIDTH  tooth pitch in clk cycles, sampled at slot boundaries.
- cap  out  1  registered wheel signal.
- tooth_idx  out  TCNT_WIDTH  current slot number, 0..TEETH_TOTAL-1.
- rev_strobe  out  1  one-cycle pulse in the first cycle of slot 0.
- busy  out  1  1 in RUN or DRAIN.

Behaviour:
- Reset values:
  - cap = CAP_INV.
  - tooth_idx = 0, rev_strobe = 0, busy = 0.
  - State IDLE; phase counter = 0; active period register = 4.
- Internal state:
  - Phase counter ph (PER_WIDTH bits) counts 0..P-1 within a slot.
  - Slot counter equals tooth_idx.
  - P is the active period register.
- Period load:
  - At every slot start (IDLE->RUN transition and ph wrap), P <= max(period, 4).
  - A period change mid-slot has no effect until the next slot start.
  - period = 0..3 is clamped to 4.
- Tooth shape:
  - In a physical slot (tooth_idx < TEETH_TOTAL-TEETH_MISSING), cap = ~CAP_INV while ph < (P>>1), else CAP_INV.
  - Gap slots hold cap = CAP_INV for the whole slot.
  - Odd P: the high portion is floor(P/2) cycles and the low portion is ceil(P/2).
- Slot advance:
  - When ph == P-1: ph <= 0 and tooth_idx increments.
  - tooth_idx wraps TEETH_TOTAL-1 -> 0.
  - rev_strobe = 1 in the cycle where tooth_idx == 0 and ph == 0.
- FSM:
  - IDLE: cap = CAP_INV, ph = 0, tooth_idx = 0. When en = 1 at cycle N: state is RUN at N+1, with ph = 0, tooth_idx = 0, cap active, rev_strobe = 1, and P loaded. Latency from en to first cap edge is 1 cycle.
  - RUN: waveform generation as above. en = 0 -> DRAIN.
  - DRAIN: completes the current slot. At ph == P-1: if en = 0, go to IDLE with tooth_idx = 0 and cap = CAP_INV; if en = 1 again, continue in RUN with a normal slot advance (no restart at slot 0).
  - en toggles inside one slot are absorbed; the slot is never truncated.
- Boundary conditions:
  - Reset asserted mid-operation forces reset values on the next edge, regardless of state.
  - Counters are sized so that P = 2^PER_WIDTH-1 does not overflow ph.
  - busy = (state != IDLE).
- Revolution length = TEETH_TOTAL*P clocks.
- Longest inactive run = TEETH_MISSING*P + ceil(P/2) clocks: the low tail of the last tooth plus the gap slots.

Test Plan:
- Reset, then en = 1 with period = 8, default params.
  - cap high 4 cycles, low 4, repeated 58 times.
  - Then low 20 cycles: 4 tail + 16 gap.
  - rev_strobe pulses every 480 cycles.
  - tooth_idx sequence 0..59..0.
- period = 9: every tooth is 4 cycles high and 5 low; revolution is 540 cycles.
- Change period 8 -> 16 at ph = 2 of slot 10.
  - Slot 10 stays 8 cycles.
  - Slot 11 onward is 8 high / 8 low.
- period = 0: clamps to 4, giving 2 high / 2 low.
- Stop/restart:
  - Drop en at ph = 1 of slot 5 (P = 8): slot 5 completes, IDLE is entered after the 8th cycle, busy falls, cap = 0, tooth_idx = 0.
  - Reassert en in DRAIN before the slot ends: no restart, slot 6 follows.
- Loopback into the angle generator (falling-edge capture):
  - Sync is achieved within 2 revolutions.
  - Angle count wraps 3839 -> 0 once per revolution.
- Assert rst mid-slot: the next cycle shows all outputs at reset values.
- Repeat the first scenario with CAP_INV = 1: the waveform is inverted.
